// File: rtl/jtframe_sdram_pkg.sv
// Shared definitions for the SDRAM slot arbiter: controller state encoding and
// default SDRAM word address width.
package jtframe_sdram_pkg;

    localparam int SDRAM_AW = 22;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_REF  = 3'd4
    } state_e;

endpackage

// File: rtl/jtframe_rr_pick.sv
// Round-robin pick: first asserted request scanning from ptr upwards, wrapping
// modulo NSLOT. Purely combinational.
module jtframe_rr_pick #(
    parameter int NSLOT = 4,
    parameter int PW    = $clog2(NSLOT)
) (
    input  logic [NSLOT-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    idx,
    output logic             valid
);

    localparam int unsigned N = NSLOT;

    int unsigned k;
    logic [PW-1:0] kk;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        kk    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            kk = PW'(k);
            if (!valid && req[kk]) begin
                valid = 1'b1;
                idx   = kk;
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Shares one SDRAM sequencer port among NSLOT request slots: round-robin grant,
// one transaction in flight, periodic auto-refresh with priority over slots.
module jtframe_sdram_arb
    import jtframe_sdram_pkg::*;
#(
    parameter int NSLOT  = 4,
    parameter int REFCNT = 390,
    parameter int AW     = SDRAM_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSLOT-1:0]    slot_req,
    input  logic [NSLOT-1:0]    slot_rnw,
    input  logic [NSLOT*AW-1:0] slot_addr,
    input  logic [NSLOT*16-1:0] slot_wrdata,
    input  logic [NSLOT*2-1:0]  slot_wrmask,
    output logic [31:0]         din,
    output logic                din_ok,
    output logic [NSLOT-1:0]    we,
    output logic                sdram_req,
    output logic                sdram_rnw,
    output logic [AW-1:0]       sdram_addr,
    output logic [15:0]         sdram_din,
    output logic [1:0]          sdram_mask,
    output logic                sdram_refresh,
    input  logic                sdram_ack,
    input  logic                sdram_rdy,
    input  logic [31:0]         sdram_dout
);

    localparam int PW = $clog2(NSLOT);
    localparam int CW = $clog2(REFCNT);

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [NSLOT-1:0] we_q, we_d;
    logic [31:0]     din_q, din_d;
    logic            rnw_q, rnw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     wd_q, wd_d;
    logic [1:0]      mask_q, mask_d;

    logic [PW-1:0]   pick_idx;
    logic            pick_valid;
    logic            cnt_wrap;

    jtframe_rr_pick #(
        .NSLOT (NSLOT),
        .PW    (PW)
    ) u_pick (
        .req   (slot_req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        pend_d   = pend_q;
        we_d     = we_q;
        din_d    = din_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        mask_d   = mask_q;
        cnt_wrap = (cnt_q == CW'(REFCNT - 1));
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_REF;
                end else if (pick_valid) begin
                    state_d = ST_CMD;
                    rnw_d   = slot_rnw[pick_idx];
                    addr_d  = slot_addr[pick_idx*AW +: AW];
                    wd_d    = slot_wrdata[pick_idx*16 +: 16];
                    mask_d  = slot_wrmask[pick_idx*2 +: 2];
                    we_d    = '0;
                    we_d[pick_idx] = 1'b1;
                    ptr_d   = (pick_idx == PW'(NSLOT - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            ST_CMD: begin
                if (sdram_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sdram_rdy) begin
                    if (rnw_q) begin
                        din_d = sdram_dout;
                    end
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
                we_d    = '0;
            end
            ST_REF: begin
                if (sdram_ack) begin
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A wrap landing on the refresh ack cycle starts a fresh interval.
        if (cnt_wrap) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            we_q    <= '0;
            din_q   <= '0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            we_q    <= we_d;
            din_q   <= din_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            mask_q  <= mask_d;
        end
    end

    assign din           = din_q;
    assign din_ok        = (state_q == ST_HOLD);
    assign we            = we_q;
    assign sdram_req     = (state_q == ST_CMD);
    assign sdram_rnw     = rnw_q;
    assign sdram_addr    = addr_q;
    assign sdram_din     = wd_q;
    assign sdram_mask    = mask_q;
    assign sdram_refresh = (state_q == ST_REF);

endmodule
